// File: rtl/multi_pkg.sv
// rtl/multi_pkg.sv - shared types, width helpers and operand-select constants for the matrix-multiply core
package multi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      STORE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // Element index width; a 1x1 matrix still needs one address bit.
   function automatic int addr_width(input int n);
      return (n * n > 1) ? $clog2(n * n) : 1;
   endfunction

   // A dot product of n DW-bit signed terms fits in 2*DW + clog2(n) bits.
   function automatic int acc_width(input int n, input int dw);
      return 2 * dw + $clog2(n);
   endfunction

endpackage

// File: rtl/multi_mac.sv
// rtl/multi_mac.sv - single signed multiply-accumulate unit with clear and enable
module multi_mac #(
   parameter int DW    = 8,
   parameter int ACC_W = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [DW-1:0]    a,
   input  logic [DW-1:0]    b,
   output logic [ACC_W-1:0] acc
);

   logic signed [2*DW-1:0] prod;

   assign prod = $signed(a) * $signed(b);

   // Accumulate the sign-extended product; clear wins over enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + ACC_W'(prod);
      end
   end

endmodule

// File: rtl/multi_mmul_core.sv
// rtl/multi_mmul_core.sv - N x N signed matrix multiply core with operand/result register arrays
module multi_mmul_core
   import multi_pkg::*;
#(
   parameter int N     = 2,
   parameter int DW    = 8,
   parameter int AW    = addr_width(N),
   parameter int ACC_W = acc_width(N, DW)
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic             op_we,
   input  logic             op_sel,
   input  logic [AW-1:0]    op_addr,
   input  logic [DW-1:0]    op_wdata,
   input  logic             start,
   input  logic [AW-1:0]    res_addr,
   output logic [ACC_W-1:0] res_rdata,
   output logic             busy,
   output logic             done
);

   localparam int NN = N * N;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t          state;
   logic [CW-1:0]   i;
   logic [CW-1:0]   j;
   logic [CW-1:0]   k;
   logic [DW-1:0]   a_mem [NN];
   logic [DW-1:0]   b_mem [NN];
   logic [ACC_W-1:0] c_mem [NN];

   logic [AW-1:0]   a_idx;
   logic [AW-1:0]   b_idx;
   logic [AW-1:0]   c_idx;
   logic            idle_like;
   logic            mac_clr;
   logic            mac_en;
   logic [ACC_W-1:0] acc;

   assign a_idx     = AW'(int'(i) * N + int'(k));
   assign b_idx     = AW'(int'(k) * N + int'(j));
   assign c_idx     = AW'(int'(i) * N + int'(j));
   assign idle_like = (state == IDLE) || (state == DONE);
   assign mac_clr   = (idle_like && start) || (state == STORE);
   assign mac_en    = (state == MAC);

   multi_mac #(
      .DW    (DW),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .clr   (mac_clr),
      .en    (mac_en),
      .a     (a_mem[a_idx]),
      .b     (b_mem[b_idx]),
      .acc   (acc)
   );

   // Sequencer, counters, operand/result storage and the registered result read port.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state     <= IDLE;
         i         <= '0;
         j         <= '0;
         k         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         res_rdata <= '0;
         for (int n = 0; n < NN; n++) begin
            a_mem[n] <= '0;
            b_mem[n] <= '0;
            c_mem[n] <= '0;
         end
      end else begin
         res_rdata <= (int'(res_addr) < NN) ? c_mem[res_addr] : '0;
         case (state)
            IDLE, DONE: begin
               if (op_we && (int'(op_addr) < NN)) begin
                  if (op_sel == SEL_A) a_mem[op_addr] <= op_wdata;
                  else                 b_mem[op_addr] <= op_wdata;
               end
               if (start) begin
                  state <= MAC;
                  i     <= '0;
                  j     <= '0;
                  k     <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            MAC: begin
               if (k == LAST) state <= STORE;
               else           k     <= k + CW'(1);
            end
            STORE: begin
               c_mem[c_idx] <= acc;
               k            <= '0;
               state        <= MAC;
               if (j == LAST) begin
                  j <= '0;
                  if (i == LAST) begin
                     i     <= '0;
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     i <= i + CW'(1);
                  end
               end else begin
                  j <= j + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_mmul_core.sv
// tb/tb_multi_mmul_core.sv - self-checking bench for multi_mmul_core against a plain arithmetic matrix model
module tb_multi_mmul_core;

   localparam int N     = 2;
   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int ACC_W = 17;
   localparam int NN    = N * N;
   localparam int LAT   = N * N * (N + 1);

   logic             ACLK     = 1'b0;
   logic             ARESETN  = 1'b0;
   logic             op_we    = 1'b0;
   logic             op_sel   = 1'b0;
   logic [AW-1:0]    op_addr  = '0;
   logic [DW-1:0]    op_wdata = '0;
   logic             start    = 1'b0;
   logic [AW-1:0]    res_addr = '0;
   logic [ACC_W-1:0] res_rdata;
   logic             busy;
   logic             done;

   int     compared   = 0;
   int     mismatched = 0;
   int     ma [NN];
   int     mb [NN];
   longint mc [NN];

   multi_mmul_core #(.N(N), .DW(DW)) dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .op_we     (op_we),
      .op_sel    (op_sel),
      .op_addr   (op_addr),
      .op_wdata  (op_wdata),
      .start     (start),
      .res_addr  (res_addr),
      .res_rdata (res_rdata),
      .busy      (busy),
      .done      (done)
   );

   always #5 ACLK = ~ACLK;

   task automatic tick();
      @(negedge ACLK);
   endtask

   task automatic check(input string tag, input longint obs, input longint exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint rdata_s();
      return longint'($signed(res_rdata));
   endfunction

   task automatic load(input logic sel, input int idx, input int val);
      op_we    = 1'b1;
      op_sel   = sel;
      op_addr  = AW'(idx);
      op_wdata = DW'(val);
      tick();
      op_we    = 1'b0;
      if (sel) mb[idx] = val;
      else     ma[idx] = val;
   endtask

   task automatic load_all(input int a0, a1, a2, a3, input int b0, b1, b2, b3);
      load(1'b0, 0, a0); load(1'b0, 1, a1); load(1'b0, 2, a2); load(1'b0, 3, a3);
      load(1'b1, 0, b0); load(1'b1, 1, b1); load(1'b1, 2, b2); load(1'b1, 3, b3);
   endtask

   function automatic void model_product();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            longint s = 0;
            for (int t = 0; t < N; t++) s += longint'(ma[r*N+t]) * longint'(mb[t*N+c]);
            mc[r*N+c] = s;
         end
   endfunction

   // Start, optionally poke start/op_we at busy cycle 'poke', wait for done within a budget.
   task automatic run_mmul(input string tag, input int poke);
      int cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, ".busy_rise"}, busy, 1);
      check({tag, ".done_clear"}, done, 0);
      cyc = 0;
      while (!done && cyc < 200) begin
         if (cyc == poke) begin
            start = 1'b1; op_we = 1'b1; op_sel = 1'b0; op_addr = '0; op_wdata = 8'd99;
         end else begin
            start = 1'b0; op_we = 1'b0;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      op_we = 1'b0;
      check({tag, ".latency"}, cyc, LAT);
      check({tag, ".busy_fall"}, busy, 0);
      model_product();
   endtask

   task automatic read_all(input string tag);
      for (int n = 0; n < NN; n++) begin
         res_addr = AW'(n);
         tick();
         check($sformatf("%s.c%0d", tag, n), rdata_s(), mc[n]);
      end
   endtask

   initial begin
      for (int n = 0; n < NN; n++) begin ma[n] = 0; mb[n] = 0; mc[n] = 0; end

      tick();
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      check("reset.rdata", rdata_s(), 0);
      ARESETN = 1'b1;
      tick();
      read_all("reset");

      load_all(1, 2, 3, 4, 5, 6, 7, 8);
      run_mmul("basic", -1);
      check("basic.ref19", mc[0], 19);
      check("basic.ref50", mc[3], 50);
      read_all("basic");

      res_addr = '0;
      tick();
      for (int n = 1; n < NN; n++) begin
         res_addr = AW'(n);
         #1;
         check($sformatf("lat.hold%0d", n), rdata_s(), mc[n-1]);
         tick();
         check($sformatf("lat.new%0d", n), rdata_s(), mc[n]);
      end

      run_mmul("ignore", 4);
      read_all("ignore");
      run_mmul("ignore2", -1);
      read_all("ignore2");

      load_all(-128, -128, -128, -128, -128, -128, -128, -128);
      run_mmul("neg_neg", -1);
      check("neg_neg.ref", mc[0], 32768);
      read_all("neg_neg");
      load_all(-128, -128, -128, -128, 127, 127, 127, 127);
      run_mmul("neg_pos", -1);
      check("neg_pos.ref", mc[2], -32512);
      read_all("neg_pos");

      load_all(1, 2, 3, 4, 5, 6, 7, 8);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #2 ARESETN = 1'b0;
      #1;
      check("rst_mid.busy", busy, 0);
      check("rst_mid.done", done, 0);
      check("rst_mid.rdata", rdata_s(), 0);
      for (int n = 0; n < NN; n++) begin ma[n] = 0; mb[n] = 0; mc[n] = 0; end
      tick();
      ARESETN = 1'b1;
      read_all("rst_mid");
      load_all(1, 2, 3, 4, 5, 6, 7, 8);
      run_mmul("rst_reload", -1);
      read_all("rst_reload");

      load_all(1, 2, 3, 4, 1, 0, 0, 1);
      run_mmul("b2b", -1);
      read_all("b2b");

      for (int r = 0; r < 4; r++) begin
         for (int n = 0; n < NN; n++) load(1'b0, n, int'($urandom_range(255)) - 128);
         for (int n = 0; n < NN; n++) load(1'b1, n, int'($urandom_range(255)) - 128);
         run_mmul($sformatf("rand%0d", r), -1);
         read_all($sformatf("rand%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/multi_mmul_core.md
# multi_mmul_core

Matrix-multiply compute core sitting directly behind the multi AXI4-Lite slave register file. The slave forwards operand writes, a start strobe and result-read addresses; this block stores two N×N signed operand matrices and computes C = A·B with one sequential multiply-accumulate unit. It returns result elements to the slave's read path and reports busy/done status.

## Interface
- N, default 2: matrix dimension (N ≥ 1).
- DW, default 8: operand element width, signed two's complement.
- AW, derived = max(1, $clog2(N*N)): element index width.
- ACC_W, derived = 2*DW + $clog2(N): result element width, signed; never overflows.
- ACLK  in  1  clock; all state updates on the rising edge.
- ARESETN  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- op_we  in  1  operand write strobe, one element per cycle.
- op_sel  in  1  0 = matrix A, 1 = matrix B.
- op_addr  in  AW  row-major index, i*N+j.
- op_wdata  in  DW  operand element.
- start  in  1  single-cycle start strobe.
- res_addr  in  AW  row-major result index.
- res_rdata  out  ACC_W  registered C[res_addr]; reset 0.
- busy  out  1  computation in progress; reset 0.
- done  out  1  sticky completion flag; reset 0.

## Operation
- FSM states: IDLE, MAC, STORE, DONE. Reset state: IDLE.
- IDLE or DONE with start=1: go to MAC. Clear i, j, k and acc. Set busy=1 and done=0.
- MAC: acc += A[i][k]*B[k][j], full-precision signed. Then k++. When k==N-1, go to STORE.
- STORE: C[i*N+j] <= acc. Clear acc and k. Advance j, wrapping to 0 and incrementing i at j==N-1.
  - If i==N-1 and j==N-1: go to DONE, busy=0, done=1.
  - Otherwise: go to MAC.
- DONE: hold done=1 until the next accepted start.
- Operand writes are accepted only in IDLE and DONE. While busy, op_we is ignored and the operands stay unchanged.
- start is ignored while busy.
- A, B and C are cleared to 0 on reset only. start does not clear C.
- Out-of-range indices (≥ N*N, when N*N is not a power of 2):
  - Writes are dropped.
  - Reads return 0.
- Reads during busy return the currently stored C value: the new value for elements already stored, the previous value otherwise.
- Reset mid-operation returns immediately to IDLE. All outputs, A, B, C and the counters are zeroed.

## Timing
- Operand write: the element is updated on the op_we edge and is visible to a MAC on the next cycle.
- Result read latency: 1 cycle. res_rdata at edge t+1 reflects res_addr at edge t.
- A C element written at a STORE edge is readable via res_rdata one edge later.
- Per element: N MAC edges plus 1 STORE edge.
- done rises at the edge N*N*(N+1) cycles after the start edge, which is 12 cycles for N=2. busy falls at the same edge.
- busy rises at the edge that samples start.
- start arriving at the same edge as completion is ignored, because state is still STORE.
- Back-to-back operation: start in DONE clears done on the next edge and restarts.

## Structure
- Package multi_pkg holds:
  - the state enum (IDLE, MAC, STORE, DONE);
  - the ACC_W and AW derivation functions;
  - the op_sel constants SEL_A=0 and SEL_B=1.
- Sub-module multi_mac: signed DW×DW multiplier plus ACC_W accumulator with clear and enable inputs, no internal pipeline.
- The top level holds the FSM, the i/j/k counters, the A/B/C register arrays and the registered read mux.

## Test plan
- Basic product, N=2: A={1,2,3,4}, B={5,6,7,8}, start -> busy for 12 cycles, then done=1. Reading C gives 19, 22, 43, 50.
- Signed extremes: all A and B elements = -128 -> every C element = 32768 (17'h08000). All A = -128, all B = 127 -> every C element = -32512.
- Ignored inputs while busy: start and op_we pulsed at cycle 4 of busy -> completion is still at cycle 12, results are unchanged from the basic product, and A/B read back unchanged in a second run.
- Reset mid-operation: ARESETN low asynchronously at cycle 5 -> busy, done and res_rdata drop to 0 immediately, C reads 0. Reload and restart -> correct 19, 22, 43, 50.
- Back-to-back run: after done, load B = identity and start -> done=0 on the next edge. After 12 cycles, C = {1,2,3,4}.
- Read latency check: sweep res_addr 0..3 every cycle after done -> res_rdata trails res_addr by exactly one cycle.
